fcl_train_sequencer: RTL and testbench
======================================

Name: fcl_train_sequencer

Overview:
- Sequences training of the fully connected layer on a single clock. Seeds the weight array from the LFSR, then runs each sample through forward pass, result hand-off, error intake and weight commit.
- Repeats this for NUM_SAMPLES samples per epoch over NUM_EPOCHS epochs.
- Sits between the sample source / loss unit and the fully_connected_layer instance, and is the sole owner of the layer's weight registers.

Parameters:
- WIDTH, 16, bit width of every data, weight and error word (signed).
- INPUT_DIM, 4, layer input count; the weight array has INPUT_DIM+1 rows, the last row being bias.
- OUTPUT_DIM, 10, layer output count.
- FWD_LATENCY, 1, cycles from sample latch to output capture; legal range is 1 or more.
- NUM_SAMPLES, 8, samples per epoch; 2 or more.
- NUM_EPOCHS, 4, epochs before done; 1 or more.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- lfsr_word  in  WIDTH*OUTPUT_DIM  random word; lane j is bits [j*WIDTH +: WIDTH].
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accept.
- in_data  in  WIDTH x INPUT_DIM  sample vector.
- fcl_input_data  out  WIDTH x INPUT_DIM  latched sample driven to the layer.
- fcl_output_error  out  WIDTH x OUTPUT_DIM  latched error driven to the layer.
- fcl_input_weights  out  WIDTH x (INPUT_DIM+1) x OUTPUT_DIM  weight registers driven to the layer.
- fcl_output_data  in  WIDTH x OUTPUT_DIM  layer forward result.
- fcl_output_weights  in  WIDTH x (INPUT_DIM+1) x OUTPUT_DIM  layer updated weights.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_data  out  WIDTH x OUTPUT_DIM  captured forward result.
- err_valid  in  1  error valid.
- err_ready  out  1  error accept.
- err_data  in  WIDTH x OUTPUT_DIM  output error vector.
- sample_count  out  $clog2(NUM_SAMPLES)  index of the current sample within the epoch.
- epoch_count  out  $clog2(NUM_EPOCHS)+1  completed epochs.
- done  out  1  training finished.

Behaviour:

Reset:
- On reset high at a clk edge: state=INIT, row counter=0, sample_count=0, epoch_count=0.
- All of the following clear to 0: in_ready, out_valid, err_ready, done, out_data, fcl_input_data, fcl_output_error, fcl_input_weights.
- Reset mid-operation abandons everything in flight, including any pending handshake. No partial weight commit survives.

States: INIT, WAIT_IN, FWD, PRESENT, WAIT_ERR, UPDATE, DONE.

INIT:
- Each cycle, weights[row][j] <= lfsr_word lane j for all j, then row++.
- After writing row INPUT_DIM, go to WAIT_IN. INIT lasts INPUT_DIM+1 cycles, so in_ready first reads high INPUT_DIM+1 cycles after reset falls.

WAIT_IN:
- in_ready=1 (registered, high for the whole state).
- On in_valid and in_ready: fcl_input_data <= in_data, fcl_output_error <= 0, fwd counter=0, go to FWD.

FWD:
- Counter increments each cycle.
- On the cycle where counter==FWD_LATENCY-1: out_data <= fcl_output_data, out_valid <= 1, go to PRESENT. The first capture edge is therefore FWD_LATENCY edges after the accept edge.

PRESENT:
- out_valid held high and out_data held stable until out_ready.
- On handshake: out_valid <= 0, err_ready <= 1, go to WAIT_ERR.

WAIT_ERR:
- On err_valid and err_ready: fcl_output_error <= err_data, err_ready <= 0, go to UPDATE.

UPDATE (exactly 1 cycle):
- fcl_input_weights <= fcl_output_weights. fcl_input_data and fcl_output_error stay stable during this cycle.
- Then fcl_output_error <= 0.
- If sample_count==NUM_SAMPLES-1: sample_count <= 0 and epoch_count++. If the new epoch_count==NUM_EPOCHS go to DONE, else go to WAIT_IN.
- Otherwise sample_count++ and go to WAIT_IN.

DONE:
- done=1, in_ready=0, weights frozen. Only reset exits this state.

Handshakes:
- No combinational ready/valid paths; all three handshakes use registered signals.
- in_valid or err_valid asserted outside their accepting state is ignored; no buffering.
- A valid and its ready may rise in the same cycle; the transfer happens at that edge.

Datapath:
- Weights change only in INIT and UPDATE. fcl_input_weights always equals the weight registers.
- All arithmetic is inside the layer. This block performs only WIDTH-wide register copies, with no sign change or truncation.

Test Plan:
- Reset, lfsr_word=each lane 16'h0001 -> after 5 cycles all 5x10 weights=1; in_ready high on cycle 5 after reset release; done=0.
- Reset asserted on the 3rd INIT cycle -> rows 0-1 cleared to 0; INIT restarts at row 0; in_ready stays low for 5 cycles after release.
- Sample in_data={1,2,3,4} with FWD_LATENCY=1 -> fcl_input_data={1,2,3,4} after the accept edge; out_valid 1 cycle later carrying the layer output; out_ready held low for 4 cycles -> out_valid and out_data stay stable.
- err_data all 16'h0002 offered while in PRESENT -> ignored. After out handshake, err accepted; one UPDATE cycle copies fcl_output_weights (stub layer returns weights+err); sample_count 0->1; fcl_output_error returns to 0.
- NUM_SAMPLES=2, NUM_EPOCHS=2, 4 full samples -> epoch_count increments after samples 2 and 4; done=1 after the 4th UPDATE; a subsequent in_valid gets no in_ready.
- in_valid and out_ready held high, err_valid high one cycle after err_ready -> back-to-back samples; each sample takes 1+FWD_LATENCY+1+1+1 cycles from accept to next in_ready.

Source files
------------

// File: rtl/fcl_train_sequencer.sv
// fcl_train_sequencer: owns the layer weights and steps each sample through
// forward, result hand-off, error intake and commit over all epochs.
module fcl_train_sequencer #(
  parameter int WIDTH       = 16,
  parameter int INPUT_DIM   = 4,
  parameter int OUTPUT_DIM  = 10,
  parameter int FWD_LATENCY = 1,
  parameter int NUM_SAMPLES = 8,
  parameter int NUM_EPOCHS  = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [WIDTH*OUTPUT_DIM-1:0]                lfsr_word,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [WIDTH*INPUT_DIM-1:0]                 in_data,
  output logic [WIDTH*INPUT_DIM-1:0]                 fcl_input_data,
  output logic [WIDTH*OUTPUT_DIM-1:0]                fcl_output_error,
  output logic [WIDTH*(INPUT_DIM+1)*OUTPUT_DIM-1:0]  fcl_input_weights,
  input  logic [WIDTH*OUTPUT_DIM-1:0]                fcl_output_data,
  input  logic [WIDTH*(INPUT_DIM+1)*OUTPUT_DIM-1:0]  fcl_output_weights,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [WIDTH*OUTPUT_DIM-1:0]                out_data,
  input  logic                                       err_valid,
  output logic                                       err_ready,
  input  logic [WIDTH*OUTPUT_DIM-1:0]                err_data,
  output logic [$clog2(NUM_SAMPLES)-1:0]             sample_count,
  output logic [$clog2(NUM_EPOCHS):0]                epoch_count,
  output logic                                       done
);
  localparam int LANES = WIDTH * OUTPUT_DIM;
  localparam int RW    = $clog2(INPUT_DIM + 1);
  localparam int FW    = $clog2(FWD_LATENCY + 1);
  localparam int SW    = $clog2(NUM_SAMPLES);
  localparam int EW    = $clog2(NUM_EPOCHS) + 1;

  typedef enum logic [2:0] {INIT, WAIT_IN, FWD, PRESENT, WAIT_ERR, UPDATE, DONE} state_t;

  state_t                                      r_state, w_next;
  logic [RW-1:0]                               r_row;
  logic [FW-1:0]                               r_fwd;
  logic [SW-1:0]                               r_sample;
  logic [EW-1:0]                               r_epoch, w_epoch_next;
  logic                                        r_in_ready, r_out_valid, r_err_ready, r_done;
  logic [LANES-1:0]                            r_out_data, r_err;
  logic [WIDTH*INPUT_DIM-1:0]                  r_in_data;
  logic [WIDTH*(INPUT_DIM+1)*OUTPUT_DIM-1:0]   r_w;
  logic w_init, w_accept, w_fwd, w_capture, w_out_hs, w_err_hs, w_update, w_last, w_row_last;

  always_ff @(posedge clk)
    if (reset) r_state <= INIT;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      INIT:     w_next = w_row_last ? WAIT_IN : INIT;
      WAIT_IN:  w_next = w_accept ? FWD : WAIT_IN;
      FWD:      w_next = w_capture ? PRESENT : FWD;
      PRESENT:  w_next = w_out_hs ? WAIT_ERR : PRESENT;
      WAIT_ERR: w_next = w_err_hs ? UPDATE : WAIT_ERR;
      UPDATE:   w_next = (w_last && w_epoch_next == EW'(NUM_EPOCHS)) ? DONE : WAIT_IN;
      DONE:     w_next = DONE;
      default:  w_next = INIT;
    endcase
  end

  always_comb begin
    w_init       = r_state == INIT;
    w_row_last   = r_row == RW'(INPUT_DIM);
    w_accept     = r_state == WAIT_IN && in_valid && r_in_ready;
    w_fwd        = r_state == FWD;
    w_capture    = w_fwd && r_fwd == FW'(FWD_LATENCY - 1);
    w_out_hs     = r_state == PRESENT && r_out_valid && out_ready;
    w_err_hs     = r_state == WAIT_ERR && err_valid && r_err_ready;
    w_update     = r_state == UPDATE;
    w_last       = r_sample == SW'(NUM_SAMPLES - 1);
    w_epoch_next = r_epoch + EW'(1);
  end

  // Handshake flags are registered from the next state so each is high for its whole state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row       <= '0;
      r_fwd       <= '0;
      r_sample    <= '0;
      r_epoch     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_err_ready <= 1'b0;
      r_done      <= 1'b0;
      r_out_data  <= '0;
      r_in_data   <= '0;
      r_err       <= '0;
      r_w         <= '0;
    end else begin
      r_in_ready  <= w_next == WAIT_IN;
      r_out_valid <= w_next == PRESENT;
      r_err_ready <= w_next == WAIT_ERR;
      r_done      <= w_next == DONE;
      r_fwd       <= w_fwd ? r_fwd + FW'(1) : '0;
      if (w_init) begin
        r_w[r_row*LANES +: LANES] <= lfsr_word;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end
      if (w_accept) begin
        r_in_data <= in_data;
        r_err     <= '0;
      end
      if (w_capture) r_out_data <= fcl_output_data;
      if (w_err_hs) r_err <= err_data;
      if (w_update) begin
        r_w      <= fcl_output_weights;
        r_err    <= '0;
        r_sample <= w_last ? '0 : r_sample + SW'(1);
        if (w_last) r_epoch <= w_epoch_next;
      end
    end
  end

  assign in_ready          = r_in_ready;
  assign out_valid         = r_out_valid;
  assign err_ready         = r_err_ready;
  assign done              = r_done;
  assign out_data          = r_out_data;
  assign fcl_input_data    = r_in_data;
  assign fcl_output_error  = r_err;
  assign fcl_input_weights = r_w;
  assign sample_count      = r_sample;
  assign epoch_count       = r_epoch;
endmodule

// File: tb/tb_fcl_train_sequencer.sv
// tb_fcl_train_sequencer: scoreboard bench with a stub layer (out = input lane + index,
// new weights = weights + error lane) for a 2-sample, 2-epoch run.
module tb_fcl_train_sequencer;
  localparam int W = 16, ID = 4, OD = 10, ROWS = ID + 1, LW = W * OD, WW = W * ROWS * OD;

  logic            clk = 1'b0, reset = 1'b1;
  logic [LW-1:0]   lfsr_word, fcl_output_error, fcl_output_data, out_data, err_data;
  logic            in_valid, in_ready, out_valid, out_ready, err_valid, err_ready, done;
  logic [W*ID-1:0] in_data, fcl_input_data;
  logic [WW-1:0]   fcl_input_weights, fcl_output_weights, exp_w;
  logic [0:0]      sample_count;
  logic [1:0]      epoch_count;
  logic [LW-1:0]   q[$];
  int              n_chk = 0, n_fail = 0, m_s = 0, m_e = 0;

  fcl_train_sequencer #(.WIDTH(W), .INPUT_DIM(ID), .OUTPUT_DIM(OD), .FWD_LATENCY(1),
                        .NUM_SAMPLES(2), .NUM_EPOCHS(2)) dut (
    .clk(clk), .reset(reset), .lfsr_word(lfsr_word), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fcl_input_data(fcl_input_data), .fcl_output_error(fcl_output_error),
    .fcl_input_weights(fcl_input_weights), .fcl_output_data(fcl_output_data),
    .fcl_output_weights(fcl_output_weights), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err_valid(err_valid), .err_ready(err_ready), .err_data(err_data),
    .sample_count(sample_count), .epoch_count(epoch_count), .done(done));

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] splat(input logic [W-1:0] v);
    logic [LW-1:0] r;
    for (int j = 0; j < OD; j++) r[j*W +: W] = v;
    return r;
  endfunction

  function automatic logic [LW-1:0] pat(input int k);
    logic [LW-1:0] r;
    for (int j = 0; j < OD; j++) r[j*W +: W] = W'(k * 16 + j + 1);
    return r;
  endfunction

  function automatic logic [LW-1:0] f_out(input logic [W*ID-1:0] d);
    logic [LW-1:0] r;
    for (int j = 0; j < OD; j++) r[j*W +: W] = d[(j % ID)*W +: W] + W'(j);
    return r;
  endfunction

  function automatic logic [WW-1:0] f_upd(input logic [WW-1:0] w, input logic [LW-1:0] e);
    logic [WW-1:0] r;
    for (int k = 0; k < ROWS; k++)
      for (int j = 0; j < OD; j++) r[(k*OD+j)*W +: W] = w[(k*OD+j)*W +: W] + e[j*W +: W];
    return r;
  endfunction

  assign fcl_output_data    = f_out(fcl_input_data);
  assign fcl_output_weights = f_upd(fcl_input_weights, fcl_output_error);

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every out handshake pops one expected result.
  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("sb_unexpected_out", WW'(out_data), WW'(0));
      else chk("sb_out_data", WW'(out_data), WW'(q.pop_front()));
    end

  task automatic run_sample(input logic [W*ID-1:0] d, input logic [LW-1:0] e);
    in_data = d;
    q.push_back(f_out(d));
    chk("b2b_ready_pre", WW'(in_ready), WW'(1));
    step;
    chk("b2b_ready_low", WW'(in_ready), WW'(0));
    chk("b2b_in_data", WW'(fcl_input_data), WW'(d));
    step;
    chk("b2b_out_valid", WW'(out_valid), WW'(1));
    step;
    chk("b2b_out_valid_drop", WW'(out_valid), WW'(0));
    chk("b2b_err_ready", WW'(err_ready), WW'(1));
    err_valid = 1'b1;
    err_data  = e;
    exp_w     = f_upd(exp_w, e);
    step;
    err_valid = 1'b0;
    chk("b2b_err_latched", WW'(fcl_output_error), WW'(e));
    chk("b2b_err_ready_low", WW'(err_ready), WW'(0));
    step;
    if (m_s == 1) begin m_s = 0; m_e++; end
    else m_s++;
    chk("b2b_weights", fcl_input_weights, exp_w);
    chk("b2b_sample_count", WW'(sample_count), WW'(m_s));
    chk("b2b_epoch_count", WW'(epoch_count), WW'(m_e));
    chk("b2b_done", WW'(done), WW'(m_e == 2));
    chk("b2b_ready_next", WW'(in_ready), WW'(m_e != 2));
    chk("b2b_err_cleared", WW'(fcl_output_error), WW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W*ID-1:0] d;
    logic [LW-1:0]   e;
    in_valid = 0; out_ready = 0; err_valid = 0; in_data = '0; err_data = '0;
    lfsr_word = splat(16'h0001);
    step; step;
    chk("rst_in_ready", WW'(in_ready), WW'(0));
    chk("rst_out_valid", WW'(out_valid), WW'(0));
    chk("rst_err_ready", WW'(err_ready), WW'(0));
    chk("rst_done", WW'(done), WW'(0));
    chk("rst_out_data", WW'(out_data), WW'(0));
    chk("rst_in_data", WW'(fcl_input_data), WW'(0));
    chk("rst_err", WW'(fcl_output_error), WW'(0));
    chk("rst_weights", fcl_input_weights, WW'(0));
    chk("rst_sample", WW'(sample_count), WW'(0));
    chk("rst_epoch", WW'(epoch_count), WW'(0));
    reset = 0;
    for (int k = 0; k < ROWS; k++) begin
      chk("init_ready_low", WW'(in_ready), WW'(0));
      step;
    end
    chk("init_ready_high", WW'(in_ready), WW'(1));
    chk("init_weights_ones", fcl_input_weights, {ROWS{splat(16'h0001)}});
    chk("init_done", WW'(done), WW'(0));

    reset = 1; step; reset = 0;
    lfsr_word = splat(16'h0055);
    step; step;
    chk("init_partial", fcl_input_weights, {{(3*LW){1'b0}}, splat(16'h0055), splat(16'h0055)});
    reset = 1; step; reset = 0;
    chk("midinit_reset_weights", fcl_input_weights, WW'(0));
    exp_w = '0;
    for (int k = 0; k < ROWS; k++) begin
      lfsr_word = pat(k);
      exp_w[k*LW +: LW] = pat(k);
      chk("reinit_ready_low", WW'(in_ready), WW'(0));
      step;
    end
    chk("reinit_ready_high", WW'(in_ready), WW'(1));
    chk("reinit_weights", fcl_input_weights, exp_w);

    d = {16'd4, 16'd3, 16'd2, 16'd1};
    in_data = d; in_valid = 1;
    q.push_back(f_out(d));
    step;
    in_valid = 0;
    chk("s0_in_data", WW'(fcl_input_data), WW'(d));
    chk("s0_out_valid_fwd", WW'(out_valid), WW'(0));
    chk("s0_ready_low", WW'(in_ready), WW'(0));
    err_valid = 1; err_data = splat(16'h0002);
    step;
    chk("s0_out_valid", WW'(out_valid), WW'(1));
    chk("s0_out_data", WW'(out_data), WW'(f_out(d)));
    for (int k = 0; k < 4; k++) begin
      step;
      chk("s0_hold_valid", WW'(out_valid), WW'(1));
      chk("s0_hold_data", WW'(out_data), WW'(f_out(d)));
      chk("s0_err_ignored", WW'(fcl_output_error), WW'(0));
      chk("s0_err_ready_low", WW'(err_ready), WW'(0));
    end
    out_ready = 1;
    step;
    out_ready = 0;
    chk("s0_out_drop", WW'(out_valid), WW'(0));
    chk("s0_err_ready", WW'(err_ready), WW'(1));
    chk("s0_err_not_yet", WW'(fcl_output_error), WW'(0));
    exp_w = f_upd(exp_w, splat(16'h0002));
    step;
    err_valid = 0;
    chk("s0_err_latched", WW'(fcl_output_error), WW'(splat(16'h0002)));
    chk("s0_err_ready_low2", WW'(err_ready), WW'(0));
    chk("s0_in_data_stable", WW'(fcl_input_data), WW'(d));
    chk("s0_sample_pre", WW'(sample_count), WW'(0));
    step;
    m_s = 1;
    chk("s0_weights", fcl_input_weights, exp_w);
    chk("s0_sample", WW'(sample_count), WW'(1));
    chk("s0_err_cleared", WW'(fcl_output_error), WW'(0));
    chk("s0_ready_next", WW'(in_ready), WW'(1));
    chk("s0_epoch", WW'(epoch_count), WW'(0));

    in_valid = 1; out_ready = 1;
    for (int n = 1; n < 4; n++) begin
      for (int i = 0; i < ID; i++) d[i*W +: W] = W'(n * 100 + i * 7 - 250);
      for (int j = 0; j < OD; j++) e[j*W +: W] = W'(n * 3 - j);
      run_sample(d, e);
    end
    for (int k = 0; k < 3; k++) begin
      step;
      chk("done_no_ready", WW'(in_ready), WW'(0));
      chk("done_held", WW'(done), WW'(1));
      chk("done_weights_frozen", fcl_input_weights, exp_w);
    end
    in_valid = 0; out_ready = 0;
    chk("sb_empty", WW'(q.size()), WW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
